// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter between clients A/B (req/addr/rw/wdata -> ack/rdata/rvalid) and the sdram controller (addr/rw/data_in/in_valid <- busy/out_valid/data_out), sticky timeout err
module sdram_arbiter #(
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_rw,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_rw,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic [ADDR_W-1:0] addr,
  output logic              rw,
  output logic [DATA_W-1:0] data_in,
  output logic              in_valid,
  input  logic              busy,
  input  logic [DATA_W-1:0] data_out,
  input  logic              out_valid,
  output logic              err
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t r_state, w_next;
  logic r_owner_b, r_last_b, r_got;
  logic [CNT_W-1:0] r_cnt;
  logic w_gnt_b, w_cap, w_done, w_tmo;
  always_comb begin
    w_gnt_b = b_req && (!a_req || !r_last_b);
    w_cap = r_state == WAIT_DONE && out_valid && !rw && !r_got;
    w_done = !busy && (rw || r_got || w_cap);
    w_tmo = r_cnt == CNT_W'(TIMEOUT - 1);
    w_next = r_state;
    unique case (r_state)
      IDLE:      w_next = (a_req || b_req) ? ISSUE : IDLE;
      ISSUE:     w_next = busy ? ISSUE : WAIT_BUSY;
      WAIT_BUSY: w_next = WAIT_DONE;
      default:   w_next = (w_done || w_tmo) ? IDLE : WAIT_DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner_b <= 1'b0;
      r_last_b  <= 1'b1;
      r_got     <= 1'b0;
      r_cnt     <= '0;
      addr      <= '0;
      rw        <= 1'b0;
      data_in   <= '0;
      in_valid  <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      r_state  <= w_next;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      if (r_state == IDLE && (a_req || b_req)) begin
        addr      <= w_gnt_b ? b_addr : a_addr;
        rw        <= w_gnt_b ? b_rw : a_rw;
        data_in   <= w_gnt_b ? b_wdata : a_wdata;
        r_owner_b <= w_gnt_b;
        r_last_b  <= w_gnt_b;
        in_valid  <= 1'b1;
      end
      if (r_state == ISSUE && !busy) begin
        in_valid <= 1'b0;
        a_ack    <= !r_owner_b;
        b_ack    <= r_owner_b;
        r_cnt    <= '0;
        r_got    <= 1'b0;
      end
      if (r_state == WAIT_DONE) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_cap && (w_done || !w_tmo)) begin
          r_got    <= 1'b1;
          a_rvalid <= !r_owner_b;
          b_rvalid <= r_owner_b;
          if (r_owner_b) b_rdata <= data_out;
          else a_rdata <= data_out;
        end
        if (w_tmo && !w_done) err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: randomized and directed checks of sdram_arbiter against a behavioural controller and grant model
module tb_sdram_arbiter;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int TO = 15;
  logic clk = 1'b0, rst = 1'b1;
  logic a_req = 1'b0, a_rw = 1'b0, b_req = 1'b0, b_rw = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic a_ack, b_ack, a_rvalid, b_rvalid, rw, in_valid, err;
  logic [DW-1:0] a_rdata, b_rdata, data_in;
  logic [AW-1:0] addr;
  logic busy = 1'b0, out_valid = 1'b0;
  logic [DW-1:0] data_out = '0;
  int checks = 0, failures = 0;
  bit m_rand = 1'b0;
  int m_blen = 1, m_rlat = 0, m_stall = 0;
  logic [DW-1:0] m_rdata = '0;
  bit rand_done = 1'b0;

  always #5 clk = ~clk;

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_rw(a_rw), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_addr(b_addr), .b_rw(b_rw), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .addr(addr), .rw(rw), .data_in(data_in), .in_valid(in_valid),
    .busy(busy), .data_out(data_out), .out_valid(out_valid), .err(err)
  );

  function automatic logic [DW-1:0] rd_of(input logic [AW-1:0] x);
    return ({9'h0, x} * 32'h9E3779B1) ^ 32'h5A5AA5A5;
  endfunction

  function automatic logic [125:0] outs();
    return {in_valid, rw, addr, data_in, a_ack, b_ack, a_rvalid, b_rvalid, a_rdata, b_rdata, err};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Controller model: busy for m_blen cycles after accept, out_valid on cycle m_rlat, m_stall refresh cycles before accept
  initial begin : ctrl_model
    int k;
    bit p_iv, p_busy;
    logic [AW-1:0] p_addr, c_addr;
    k = 0; p_iv = 0; p_busy = 0; p_addr = '0; c_addr = '0;
    forever begin
      @(posedge clk);
      #2;
      if (p_iv && !p_busy) begin
        k = 1;
        c_addr = p_addr;
        if (m_rand) begin
          m_blen = $urandom_range(1, 6);
          m_rlat = $urandom_range(2, m_blen + 2);
          m_stall = $urandom_range(0, 3);
        end
      end else if (k > 0) k++;
      if (k > m_blen && k > m_rlat) k = 0;
      busy = (k > 0 && k <= m_blen) || (in_valid && m_stall > 0);
      if (in_valid && m_stall > 0) m_stall--;
      out_valid = m_rlat > 0 && k == m_rlat;
      data_out = m_rand ? rd_of(c_addr) : m_rdata;
      p_iv = in_valid; p_busy = busy; p_addr = addr;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    checks++;
    if (outs() !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs()); end
    rst = 1'b0;
    cyc(5);
    checks++;
    if (in_valid !== 1'b0) begin failures++; $display("FAIL reset_idle in_valid got=%b exp=0", in_valid); end
  endtask

  task automatic test_write_a();
    int na, nb;
    m_rand = 0; m_blen = 4; m_rlat = 0; m_stall = 0;
    a_addr = 23'h000010; a_rw = 1'b1; a_wdata = 32'hDEADBEEF; a_req = 1'b1;
    cyc(1);
    checks++;
    if ({in_valid, rw, addr, data_in} !== {1'b1, 1'b1, 23'h000010, 32'hDEADBEEF}) begin
      failures++; $display("FAIL write_cmd got=%h exp=%h", {in_valid, rw, addr, data_in}, {1'b1, 1'b1, 23'h000010, 32'hDEADBEEF});
    end
    cyc(1);
    checks++;
    if ({a_ack, b_ack} !== 2'b10) begin failures++; $display("FAIL write_ack_latency got=%b exp=10", {a_ack, b_ack}); end
    na = int'(a_ack); nb = int'(b_ack);
    a_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      na += int'(a_ack); nb += int'(b_ack);
    end
    checks++;
    if (na != 1 || nb != 0) begin failures++; $display("FAIL write_ack_count got=%0d/%0d exp=1/0", na, nb); end
    checks++;
    if (in_valid !== 1'b0) begin failures++; $display("FAIL write_idle in_valid got=%b exp=0", in_valid); end
  endtask

  task automatic test_read_b();
    int n, ra, rb, lat;
    logic [DW-1:0] rd;
    logic [AW:0] cmd;
    m_rand = 0; m_blen = 6; m_rlat = 6; m_rdata = 32'h12345678; m_stall = 0;
    b_addr = 23'h7FFFFF; b_rw = 1'b0; b_wdata = 32'h0; b_req = 1'b1;
    n = 0; cmd = '1;
    do begin
      cyc(1); n++;
      if (in_valid) cmd = {rw, addr};
    end while (!b_ack && n < 20);
    checks++;
    if (b_ack !== 1'b1) begin failures++; $display("FAIL read_ack got=%b exp=1", b_ack); end
    checks++;
    if (cmd !== {1'b0, 23'h7FFFFF}) begin failures++; $display("FAIL read_cmd got=%h exp=%h", cmd, {1'b0, 23'h7FFFFF}); end
    b_req = 1'b0;
    ra = 0; rb = 0; lat = -1; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      ra += int'(a_rvalid);
      if (b_rvalid) begin rb++; rd = b_rdata; if (lat < 0) lat = i; end
    end
    checks++;
    if (rb != 1 || ra != 0) begin failures++; $display("FAIL read_rvalid_count got=%0d/%0d exp=0/1", ra, rb); end
    checks++;
    if (rd !== 32'h12345678) begin failures++; $display("FAIL read_rdata got=%h exp=12345678", rd); end
    checks++;
    if (lat != 6) begin failures++; $display("FAIL read_latency got=%0d exp=6", lat); end
  endtask

  task automatic test_round_robin();
    bit got[$];
    bit lb, e;
    int na, nb, n;
    m_rand = 1; m_stall = 0;
    a_addr = AW'($urandom); a_rw = 1'($urandom); a_wdata = $urandom;
    b_addr = AW'($urandom); b_rw = 1'($urandom); b_wdata = $urandom;
    a_req = 1'b1; b_req = 1'b1;
    na = 0; nb = 0;
    for (int c = 0; c < 400 && got.size() < 8; c++) begin
      cyc(1);
      if (a_ack) begin got.push_back(1'b0); na++; a_addr = AW'($urandom); a_rw = 1'($urandom); a_wdata = $urandom; end
      if (b_ack) begin got.push_back(1'b1); nb++; b_addr = AW'($urandom); b_rw = 1'($urandom); b_wdata = $urandom; end
    end
    b_req = 1'b0;
    n = 0;
    do begin cyc(1); n++; end while (!a_ack && n < 100);
    a_req = 1'b0;
    checks++;
    if (got.size() != 8) begin failures++; $display("FAIL rr_count got=%0d exp=8", got.size()); end
    lb = 1'b1;
    foreach (got[i]) begin
      e = !lb; lb = e;
      checks++;
      if (got[i] !== e) begin failures++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, got[i], e); end
    end
    checks++;
    if (na != 4 || nb != 4) begin failures++; $display("FAIL rr_per_port got=%0d/%0d exp=4/4", na, nb); end
    cyc(20);
    m_rand = 0;
  endtask

  task automatic test_refresh();
    logic [AW+DW:0] snap;
    bit stable, early;
    m_rand = 0; m_blen = 2; m_rlat = 0; m_stall = 20;
    a_addr = 23'h055AA5; a_rw = 1'b1; a_wdata = 32'hCAFEF00D; a_req = 1'b1;
    cyc(1);
    snap = {rw, addr, data_in};
    checks++;
    if (!in_valid || snap !== {1'b1, 23'h055AA5, 32'hCAFEF00D}) begin
      failures++; $display("FAIL refresh_cmd got=%b/%h exp=1/%h", in_valid, snap, {1'b1, 23'h055AA5, 32'hCAFEF00D});
    end
    stable = 1; early = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (!in_valid || {rw, addr, data_in} !== snap) stable = 0;
      if (a_ack || b_ack) early = 1;
    end
    checks++;
    if (!stable || early) begin failures++; $display("FAIL refresh_hold stable got=%b exp=1 early_ack got=%b exp=0", stable, early); end
    cyc(1);
    checks++;
    if ({a_ack, b_ack, in_valid} !== 3'b100) begin failures++; $display("FAIL refresh_ack got=%b exp=100", {a_ack, b_ack, in_valid}); end
    a_req = 1'b0;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL refresh_err got=%b exp=0", err); end
    cyc(6);
  endtask

  task automatic client(input bit pb, input int n, output int reads);
    logic [AW-1:0] ad;
    logic w;
    int c;
    reads = 0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) cyc(1);
      ad = AW'($urandom); w = 1'($urandom);
      if (pb) begin b_addr = ad; b_rw = w; b_wdata = $urandom; b_req = 1'b1; end
      else begin a_addr = ad; a_rw = w; a_wdata = $urandom; a_req = 1'b1; end
      c = 0;
      do begin cyc(1); c++; end while (!(pb ? b_ack : a_ack) && c < 200);
      checks++;
      if (!(pb ? b_ack : a_ack)) begin failures++; $display("FAIL rand_ack port=%0d got=0 exp=1", pb); end
      if (pb) b_req = 1'b0; else a_req = 1'b0;
      if (!w) begin
        reads++;
        c = 0;
        do begin cyc(1); c++; end while (!(pb ? b_rvalid : a_rvalid) && c < 100);
        checks++;
        if (!(pb ? b_rvalid : a_rvalid) || (pb ? b_rdata : a_rdata) !== rd_of(ad)) begin
          failures++; $display("FAIL rand_rdata port=%0d got=%h exp=%h", pb, pb ? b_rdata : a_rdata, rd_of(ad));
        end
      end
    end
  endtask

  task automatic monitor(output int ra, output int rb);
    bit p_iv, p_a, p_b, lb, eo;
    ra = 0; rb = 0; lb = 1; eo = 0;
    p_iv = in_valid; p_a = a_req; p_b = b_req;
    while (!rand_done) begin
      @(posedge clk);
      #3;
      if (in_valid && !p_iv) begin
        checks++;
        if (!(p_a || p_b)) begin failures++; $display("FAIL rand_phantom got=1 exp=0"); end
        eo = (p_a && p_b) ? !lb : p_b;
        lb = eo;
        checks++;
        if ({rw, addr, data_in} !== (eo ? {b_rw, b_addr, b_wdata} : {a_rw, a_addr, a_wdata})) begin
          failures++; $display("FAIL rand_cmd owner=%0d got=%h exp=%h", eo, {rw, addr, data_in}, eo ? {b_rw, b_addr, b_wdata} : {a_rw, a_addr, a_wdata});
        end
      end
      if (a_ack || b_ack) begin
        checks++;
        if ({a_ack, b_ack} !== (eo ? 2'b01 : 2'b10)) begin failures++; $display("FAIL rand_ack_owner got=%b exp=%b", {a_ack, b_ack}, eo ? 2'b01 : 2'b10); end
      end
      ra += int'(a_rvalid); rb += int'(b_rvalid);
      p_iv = in_valid; p_a = a_req; p_b = b_req;
    end
  endtask

  task automatic test_random();
    int rda, rdb, ma, mb;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    m_rand = 1; m_stall = 0; rand_done = 0;
    fork
      begin
        fork
          client(1'b0, 12, rda);
          client(1'b1, 12, rdb);
        join
        rand_done = 1;
      end
      monitor(ma, mb);
    join
    checks++;
    if (ma != rda || mb != rdb) begin failures++; $display("FAIL rand_rvalid_count got=%0d/%0d exp=%0d/%0d", ma, mb, rda, rdb); end
    cyc(20);
    m_rand = 0;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL rand_err got=%b exp=0", err); end
  endtask

  task automatic test_timeout();
    int n, rv;
    bit e;
    m_rand = 0; m_blen = 1000; m_rlat = 0; m_stall = 0;
    a_addr = 23'h001234; a_rw = 1'b0; a_req = 1'b1;
    n = 0;
    do begin cyc(1); n++; end while (!a_ack && n < 20);
    checks++;
    if (a_ack !== 1'b1) begin failures++; $display("FAIL tmo_ack got=%b exp=1", a_ack); end
    a_req = 1'b0;
    e = 0; rv = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      e |= err; rv += int'(a_rvalid);
    end
    checks++;
    if (e) begin failures++; $display("FAIL tmo_early_err got=1 exp=0"); end
    cyc(1);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b exp=1", err); end
    for (int i = 0; i < 10; i++) begin cyc(1); rv += int'(a_rvalid); end
    m_blen = 0;
    b_addr = 23'h000777; b_rw = 1'b1; b_wdata = 32'h0BADCAFE; b_req = 1'b1;
    n = 0;
    do begin cyc(1); n++; rv += int'(a_rvalid); end while (!b_ack && n < 50);
    checks++;
    if (b_ack !== 1'b1) begin failures++; $display("FAIL tmo_next_ack got=%b exp=1", b_ack); end
    b_req = 1'b0;
    cyc(5);
    checks++;
    if (rv != 0) begin failures++; $display("FAIL tmo_rvalid got=%0d exp=0", rv); end
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%b exp=1", err); end
  endtask

  task automatic test_mid_reset();
    int n, bad;
    m_rand = 0; m_blen = 10; m_rlat = 8; m_rdata = 32'hFEEDFACE; m_stall = 0;
    a_addr = 23'h000100; a_rw = 1'b0; a_req = 1'b1;
    n = 0;
    do begin cyc(1); n++; end while (!a_ack && n < 20);
    a_req = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    checks++;
    if (outs() !== '0) begin failures++; $display("FAIL midrst_outputs got=%h exp=0", outs()); end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      bad += int'(a_rvalid) + int'(b_rvalid) + int'(in_valid) + int'(a_ack) + int'(b_ack);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL midrst_quiet got=%0d exp=0", bad); end
    a_addr = 23'h000200; a_rw = 1'b1; a_wdata = 32'h11111111;
    b_addr = 23'h000300; b_rw = 1'b1; b_wdata = 32'h22222222;
    a_req = 1'b1; b_req = 1'b1;
    n = 0;
    do begin cyc(1); n++; end while (!a_ack && !b_ack && n < 60);
    checks++;
    if ({a_ack, b_ack} !== 2'b10) begin failures++; $display("FAIL midrst_tie got=%b exp=10", {a_ack, b_ack}); end
    a_req = 1'b0;
    n = 0;
    do begin cyc(1); n++; end while (!b_ack && n < 60);
    checks++;
    if (b_ack !== 1'b1) begin failures++; $display("FAIL midrst_second got=%b exp=1", b_ack); end
    b_req = 1'b0;
    cyc(10);
  endtask

  initial begin
    test_reset();
    test_write_a();
    test_read_b();
    test_round_robin();
    test_refresh();
    test_random();
    test_timeout();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-client round-robin arbiter directly upstream of the sdram controller.
- Accepts single-word read/write requests from ports A and B and drives the controller's command interface (addr, rw, data_in, in_valid; monitors busy, out_valid, data_out).
- Routes read data back to the requester.
- Allows one command in flight at a time, with a completion timeout and a sticky error flag.

Parameters:
- ADDR_W, 23, word address width (matches controller addr).
- DATA_W, 32, data word width.
- TIMEOUT, 1023, max cycles from acceptance to completion before abort.

Ports:
- clk  in  1  system clock (the sdram controller clock).
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  port A request; held with a_addr/a_rw/a_wdata stable until a_ack.
- a_addr  in  ADDR_W  port A word address.
- a_rw  in  1  port A direction: 1 = write, 0 = read.
- a_wdata  in  DATA_W  port A write data.
- a_ack  out  1  one-cycle pulse: port A command accepted by controller.
- a_rdata  out  DATA_W  port A read data, valid with a_rvalid.
- a_rvalid  out  1  one-cycle pulse: port A read data returned.
- b_req, b_addr, b_rw, b_wdata, b_ack, b_rdata, b_rvalid: same as the A signals, for port B.
- addr  out  ADDR_W  to controller.
- rw  out  1  to controller (1 = write).
- data_in  out  DATA_W  to controller write data.
- in_valid  out  1  to controller command strobe.
- busy  in  1  from controller.
- data_out  in  DATA_W  from controller read data.
- out_valid  in  1  from controller read-data strobe.
- err  out  1  sticky timeout flag.

Behaviour:
- Controller contract:
  - Command accepted on any cycle with in_valid=1 and busy=0.
  - busy rises no later than the cycle after acceptance.
  - Write done when busy returns low.
  - Read done when out_valid has pulsed and busy is low.
- All outputs are registered.
- Reset values: in_valid=0, addr=0, rw=0, data_in=0, a_ack=b_ack=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, err=0, last_grant=B (so A wins the first tie), state=IDLE, timeout counter=0.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req is high: choose a winner. A single requester wins outright. On a tie, grant the port not in last_grant.
  - Latch the winner's addr/rw/wdata into addr/rw/data_in, record owner, update last_grant, set in_valid=1, go to ISSUE.
  - No req: stay in IDLE.
- ISSUE:
  - If busy=0: accepted this cycle. Next cycle in_valid=0, owner ack pulses for 1 cycle, counter cleared, go to WAIT_BUSY.
  - If busy=1: hold in_valid and the command unchanged. Controller refresh stalls are tolerated indefinitely here; no timeout in ISSUE.
- WAIT_BUSY: one mandatory cycle for busy to assert, then go to WAIT_DONE.
- WAIT_DONE:
  - Counter increments each cycle.
  - If out_valid=1 while rw=0: capture data_out into the owner's rdata and pulse the owner's rvalid the next cycle. out_valid while rw=1 is ignored.
  - Exit to IDLE when busy=0 and (rw=1, or the read data has already been captured / is being captured this cycle).
  - If the counter reaches TIMEOUT first: set err=1 (sticky until rst), go to IDLE, no rvalid. A late out_valid after abort is ignored in IDLE.
- Latency:
  - A request seen in IDLE at cycle t drives in_valid at t+1.
  - Minimum ack at t+2 when busy=0.
  - Earliest next grant 3 cycles after ack.
- The loser of a tie keeps its req high. It is granted on the next IDLE visit, which guarantees alternation under continuous contention and no starvation.
- Requests are sampled only in IDLE. A req dropped before ack is a client protocol violation and is undefined.
- A client may re-assert req the cycle after its ack. It is serviced only after the current command completes.
- Reset mid-operation clears all state and outputs within one cycle. An in-flight command is abandoned and no ack/rvalid is emitted. The controller shares rst.

Test Plan:
1. A write only: a_req, a_addr=0x000010, a_rw=1, a_wdata=0xDEADBEEF; model busy high 4 cycles -> addr/data_in/rw=1 presented, single a_ack, back in IDLE, b_ack never pulses.
2. B read: b_addr=0x7FFFFF, b_rw=0; model returns out_valid with data_out=0x12345678 six cycles after accept -> exactly one b_rvalid with b_rdata=0x12345678, a_rvalid stays 0.
3. Both req continuously, 8 commands -> grants in order A,B,A,B,A,B,A,B; each port gets 4 acks.
4. busy held high 20 cycles while in ISSUE (refresh) -> in_valid and command stable throughout, ack only after busy drops, err=0.
5. TIMEOUT=15, read with no out_valid and busy stuck high -> abort after 15 cycles in WAIT_DONE, err=1 sticky, no rvalid, next request still serviced.
6. rst asserted in WAIT_DONE of a read -> next cycle all outputs 0, state IDLE, later out_valid ignored; after release a tied request is granted to A.
